// File: rtl/imem_line_responder_if.sv
// Line-read handshake between the i-cache refill port and the instruction memory.
// The requester holds read until busywait falls; readdata is valid in that cycle.
interface imem_line_responder_if;
  logic         read;
  logic [27:0]  address;
  logic [127:0] readdata;
  logic         busywait;

  modport master (
    output read,
    output address,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  read,
    input  address,
    output readdata,
    output busywait
  );
endinterface

// File: rtl/imem_line_responder.sv
// Instruction memory serving one 128-bit line per request after READ_LATENCY cycles.
// Optional IMEM_ACCESS_COUNT_EN adds a wrapping reads_served counter output.
module imem_line_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  imem_line_responder_if.slave           bus,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
`ifdef IMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]                    reads_served
`endif
);

  localparam int LW = $clog2(DEPTH_WORDS / 4);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] line_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          last_cycle;
  logic          unused_addr;

  // Upper line-address bits wrap around onto the same storage.
  assign unused_addr = ^bus.address[27:LW];
  assign last_cycle  = (state == WAIT) && (cnt == '0);

  assign bus.busywait = !reset &&
    ((state == WAIT) || ((state == IDLE) && bus.read));

  always_ff @(posedge clock) begin
    if (load_en)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      line_q       <= '0;
      bus.readdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.read) begin
            line_q <= bus.address[LW-1:0];
            cnt    <= CW'(READ_LATENCY - 1);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.readdata <= {
              mem[{line_q, 2'd3}],
              mem[{line_q, 2'd2}],
              mem[{line_q, 2'd1}],
              mem[{line_q, 2'd0}]
            };
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_ACCESS_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      reads_served <= '0;
    else if (last_cycle)
      reads_served <= reads_served + 16'd1;
  end
`endif

endmodule
